// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO pipeline controller.
//   MMIO_ADDR_W / MMIO_DATA_W / MMIO_REG_W : default bus geometry
//   mmio_req_t                             : one registered bus request
//   slot_of()                              : slot field of a word address
//   MMIO_UNUSED_PATTERN                    : read value for absent slots
package mmio_pkg;
  localparam int MMIO_ADDR_W     = 21;
  localparam int MMIO_DATA_W     = 32;
  localparam int MMIO_REG_W      = 5;
  localparam int MMIO_SLOT_W_MAX = 6;
  localparam logic [31:0] MMIO_UNUSED_PATTERN = 32'hFFFF_FFFF;

  // Sized to the package geometry; the top zero-extends narrower buses into it.
  typedef struct packed {
    logic                   cs;
    logic                   rd;
    logic                   wr;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] wr_data;
  } mmio_req_t;

  function automatic logic [MMIO_SLOT_W_MAX-1:0] slot_of(
    input logic [MMIO_ADDR_W-1:0] addr,
    input int unsigned            reg_w,
    input int unsigned            slot_w
  );
    logic [MMIO_ADDR_W-1:0] mask;
    mask = (MMIO_ADDR_W'(1) << slot_w) - MMIO_ADDR_W'(1);
    return MMIO_SLOT_W_MAX'((addr >> reg_w) & mask);
  endfunction
endpackage

// File: rtl/mmio_err_log.sv
// Internal error slot: saturating error counter, sticky flags and the
// address of the most recent bad access, plus its register read mux.
//   clk, rst     : clock, async active-high reset
//   err_unpop    : access to an unpopulated slot this cycle
//   err_illegal  : read and write both requested this cycle
//   clr          : write to reg0 of the error slot
//   bad_addr     : slot/reg bits of the current request
//   rd_reg       : register being read
//   rd_data      : reg0 = {illegal, unpop, 14'b0, cnt}, reg1 = last bad addr
// Only instantiated when MMIO_ERR_LOG_EN is defined.
module mmio_err_log #(
  parameter int                REG_W   = 5,
  parameter int                AW      = 11,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] UNUSED  = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              err_unpop,
  input  logic              err_illegal,
  input  logic              clr,
  input  logic [AW-1:0]     bad_addr,
  input  logic [REG_W-1:0]  rd_reg,
  output logic [DATA_W-1:0] rd_data
);
  logic [15:0]   cnt_d, cnt_q, cnt_base;
  logic          unpop_d, unpop_q, illegal_d, illegal_q;
  logic [AW-1:0] last_d, last_q;

  always_comb begin
    cnt_d     = cnt_q;
    unpop_d   = unpop_q;
    illegal_d = illegal_q;
    last_d    = last_q;
    // A clear in the same cycle as an error restarts the log from that error.
    cnt_base  = clr ? 16'd0 : cnt_q;
    if (clr) begin
      cnt_d     = '0;
      unpop_d   = 1'b0;
      illegal_d = 1'b0;
      last_d    = '0;
    end
    if (err_unpop || err_illegal) begin
      cnt_d  = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
      last_d = bad_addr;
      if (err_unpop)   unpop_d   = 1'b1;
      if (err_illegal) illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      unpop_q   <= 1'b0;
      illegal_q <= 1'b0;
      last_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      unpop_q   <= unpop_d;
      illegal_q <= illegal_d;
      last_q    <= last_d;
    end
  end

  always_comb begin
    rd_data = UNUSED;
    case (rd_reg)
      REG_W'(0): rd_data = DATA_W'({illegal_q, unpop_q, 14'b0, cnt_q});
      REG_W'(1): rd_data = DATA_W'(last_q);
      default:   rd_data = UNUSED;
    endcase
  end
endmodule

// File: rtl/mmio_pipe_ctrl.sv
// Pipelined MMIO controller: FPro bus -> NUM_SLOTS peripheral slots.
//   S1: request register (every cycle, no back-pressure)
//   S2: one-hot slot strobes decoded combinationally from S1
//   S3: registered read data + 1-cycle mmio_rd_valid (2-cycle read latency)
// Ports:
//   clk, reset                     : clock, async active-high reset
//   mmio_cs/read/write/addr/wr_data: bus request
//   mmio_rd_data, mmio_rd_valid    : registered read return
//   slot_cs/slot_mem_rd/slot_mem_wr: one-hot per-slot strobes
//   slot_mem_addr, slot_wr_data    : shared register address / write data
//   slot_rd_data                   : flattened per-slot read data
// Optional feature: define MMIO_ERR_LOG_EN to turn slot NUM_SLOTS-1 into the
// internal error-log slot (never forwarded to the peripheral).
module mmio_pipe_ctrl
  import mmio_pkg::*;
#(
  parameter int                   NUM_SLOTS      = 64,
  parameter int                   REG_W          = MMIO_REG_W,
  parameter int                   ADDR_W         = MMIO_ADDR_W,
  parameter int                   DATA_W         = MMIO_DATA_W,
  parameter logic [NUM_SLOTS-1:0] SLOT_PRESENT   = '1,
  parameter logic [DATA_W-1:0]    UNUSED_PATTERN = DATA_W'(MMIO_UNUSED_PATTERN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mmio_cs,
  input  logic                        mmio_read,
  input  logic                        mmio_write,
  input  logic [ADDR_W-1:0]           mmio_addr,
  input  logic [DATA_W-1:0]           mmio_wr_data,
  output logic [DATA_W-1:0]           mmio_rd_data,
  output logic                        mmio_rd_valid,
  output logic [NUM_SLOTS-1:0]        slot_cs,
  output logic [NUM_SLOTS-1:0]        slot_mem_rd,
  output logic [NUM_SLOTS-1:0]        slot_mem_wr,
  output logic [REG_W-1:0]            slot_mem_addr,
  output logic [DATA_W-1:0]           slot_wr_data,
  input  logic [NUM_SLOTS*DATA_W-1:0] slot_rd_data
);
  localparam int SLOT_W  = $clog2(NUM_SLOTS);
  localparam int AW_USED = REG_W + SLOT_W;

  // ---- S1: request register
  mmio_req_t req_d, req_q;

  always_comb begin
    req_d         = '0;
    req_d.cs      = mmio_cs;
    req_d.rd      = mmio_read;
    req_d.wr      = mmio_write;
    req_d.addr    = MMIO_ADDR_W'(mmio_addr);
    req_d.wr_data = MMIO_DATA_W'(mmio_wr_data);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_q <= '0;
    else       req_q <= req_d;
  end

  // ---- S2: decode and strobes
  logic [MMIO_SLOT_W_MAX-1:0] slot_full;
  logic [SLOT_W-1:0]          sel;
  logic [REG_W-1:0]           reg_a;
  logic [NUM_SLOTS-1:0]       onehot;
  logic                       rd_ok, wr_ok, illegal, present, err_slot, fwd;
  logic [DATA_W-1:0]          err_rd_data;
  logic [DATA_W-1:0]          slot_rd_arr [NUM_SLOTS];

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_unpack
    assign slot_rd_arr[i] = slot_rd_data[i*DATA_W +: DATA_W];
  end

  assign slot_full = slot_of(req_q.addr, REG_W, SLOT_W);
  assign sel       = slot_full[SLOT_W-1:0];
  assign reg_a     = req_q.addr[REG_W-1:0];
  assign onehot    = NUM_SLOTS'(1) << sel;
  assign rd_ok     = req_q.cs & req_q.rd & ~req_q.wr;
  assign wr_ok     = req_q.cs & req_q.wr & ~req_q.rd;
  assign illegal   = req_q.cs & req_q.rd & req_q.wr;
  assign present   = SLOT_PRESENT[sel];
  assign fwd       = present & ~err_slot;

`ifdef MMIO_ERR_LOG_EN
  logic err_unpop, err_clr;
  assign err_slot  = (sel == SLOT_W'(NUM_SLOTS-1));
  // Accesses to the error slot itself are never errors, whatever its mask bit.
  assign err_unpop = (rd_ok | wr_ok) & ~present & ~err_slot;
  assign err_clr   = wr_ok & err_slot & (reg_a == '0);

  mmio_err_log #(
    .REG_W (REG_W),
    .AW    (AW_USED),
    .DATA_W(DATA_W),
    .UNUSED(UNUSED_PATTERN)
  ) u_err_log (
    .clk        (clk),
    .rst        (reset),
    .err_unpop  (err_unpop),
    .err_illegal(illegal),
    .clr        (err_clr),
    .bad_addr   (req_q.addr[AW_USED-1:0]),
    .rd_reg     (reg_a),
    .rd_data    (err_rd_data)
  );
`else
  logic unused_illegal;
  assign err_slot       = 1'b0;
  assign err_rd_data    = '0;
  assign unused_illegal = illegal;
`endif

  always_comb begin
    slot_cs     = '0;
    slot_mem_rd = '0;
    slot_mem_wr = '0;
    if ((rd_ok | wr_ok) & fwd) begin
      slot_cs = onehot;
      if (rd_ok) slot_mem_rd = onehot;
      if (wr_ok) slot_mem_wr = onehot;
    end
  end

  assign slot_mem_addr = reg_a;
  assign slot_wr_data  = req_q.wr_data[DATA_W-1:0];

  // ---- S3: read return
  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_vld_d, rd_vld_q;

  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_ok;
    if (rd_ok) begin
      if (err_slot)     rd_data_d = err_rd_data;
      else if (!present) rd_data_d = UNUSED_PATTERN;
      else              rd_data_d = slot_rd_arr[sel];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign mmio_rd_data  = rd_data_q;
  assign mmio_rd_valid = rd_vld_q;

  // Upper address/data/slot bits are ignored by design.
  logic unused_bits;
  assign unused_bits = ^{req_q.addr, req_q.wr_data, slot_full};
endmodule

// File: tb/tb_mmio_pipe_ctrl.sv
module tb_mmio_pipe_ctrl;
  localparam logic [63:0] PRESENT = 64'hFFFF_FEFF_FFFF_FFFB; // slots 2 and 40 absent
`ifdef MMIO_ERR_LOG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 0, reset = 1;
  logic          mmio_cs = 0, mmio_read = 0, mmio_write = 0;
  logic [20:0]   mmio_addr = '0;
  logic [31:0]   mmio_wr_data = '0;
  logic [31:0]   mmio_rd_data;
  logic          mmio_rd_valid;
  logic [63:0]   slot_cs, slot_mem_rd, slot_mem_wr;
  logic [4:0]    slot_mem_addr;
  logic [31:0]   slot_wr_data;
  logic [2047:0] slot_rd_data;

  mmio_pipe_ctrl #(.NUM_SLOTS(64), .SLOT_PRESENT(PRESENT)) dut (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_read(mmio_read),
    .mmio_write(mmio_write), .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_data(mmio_rd_data), .mmio_rd_valid(mmio_rd_valid), .slot_cs(slot_cs),
    .slot_mem_rd(slot_mem_rd), .slot_mem_wr(slot_mem_wr), .slot_mem_addr(slot_mem_addr),
    .slot_wr_data(slot_wr_data), .slot_rd_data(slot_rd_data));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral environment: simple register file per slot.
  bit [31:0] periph [64][32];
  always @(posedge clk)
    for (int s = 0; s < 64; s++) if (slot_mem_wr[s]) periph[s][slot_mem_addr] <= slot_wr_data;
  always_comb begin
    slot_rd_data = '0;
    for (int s = 0; s < 64; s++) slot_rd_data[s*32 +: 32] = periph[s][slot_mem_addr];
  end

  // Reference model state
  bit [31:0] mem [64][32];
  logic [15:0] e_cnt = '0;
  logic e_ill = 0, e_unp = 0;
  logic [10:0] e_last = '0;

  typedef struct { int due; logic [63:0] cs, rd, wr; logic [4:0] a; logic [31:0] d; } strb_t;
  typedef struct { int due; logic [31:0] d; } rdx_t;
  strb_t sq[$];
  rdx_t  rq[$];

  int vecs = 0, errs = 0;
  bit mon_en = 0;
  logic [31:0] last_data = '0;

  task automatic issue(input logic cs, input logic rd, input logic wr,
                       input logic [20:0] a, input logic [31:0] d);
    strb_t s; rdx_t r; int slot, rg; bit lr, lw, fwd, is_err;
    @(posedge clk); #1;
    mmio_cs = cs; mmio_read = rd; mmio_write = wr; mmio_addr = a; mmio_wr_data = d;
    slot = int'(a[10:5]); rg = int'(a[4:0]);
    lr = cs && rd && !wr; lw = cs && wr && !rd;
    is_err = ERR_EN && slot == 63;
    fwd = PRESENT[slot] && !is_err;
    s.due = cyc + 1; s.cs = '0; s.rd = '0; s.wr = '0; s.a = a[4:0]; s.d = d;
    if ((lr || lw) && fwd) begin
      s.cs = 64'd1 << slot;
      if (lr) s.rd = s.cs; else s.wr = s.cs;
    end
    sq.push_back(s);
    if (lr) begin
      r.due = cyc + 2;
      if (is_err) r.d = (rg == 0) ? {e_ill, e_unp, 14'b0, e_cnt} :
                        (rg == 1) ? {21'b0, e_last} : 32'hFFFF_FFFF;
      else if (!PRESENT[slot]) r.d = 32'hFFFF_FFFF;
      else r.d = mem[slot][rg];
      rq.push_back(r);
    end
    if (lw && fwd) mem[slot][rg] = d;
    if ((cs && rd && wr) || ((lr || lw) && !PRESENT[slot] && !is_err)) begin
      if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
      if (cs && rd && wr) e_ill = 1; else e_unp = 1;
      e_last = a[10:0];
    end else if (lw && is_err && rg == 0) begin
      e_cnt = '0; e_ill = 0; e_unp = 0; e_last = '0;
    end
  endtask

  task automatic idle();
    issue(0, 0, 0, '0, '0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) if (mon_en) begin
    strb_t e; rdx_t r;
    if (sq.size() > 0 && sq[0].due == cyc) e = sq.pop_front();
    else begin e.cs = '0; e.rd = '0; e.wr = '0; e.a = '0; e.d = '0; e.due = cyc; end
    vecs++;
    if ({slot_cs, slot_mem_rd, slot_mem_wr} !== {e.cs, e.rd, e.wr}) begin
      errs++;
      $display("FAIL strobes cyc=%0d got cs=%h rd=%h wr=%h exp cs=%h rd=%h wr=%h",
               cyc, slot_cs, slot_mem_rd, slot_mem_wr, e.cs, e.rd, e.wr);
    end
    if (e.cs != 0) begin
      vecs++;
      if (slot_mem_addr !== e.a || (e.wr != 0 && slot_wr_data !== e.d)) begin
        errs++;
        $display("FAIL slot_bus cyc=%0d got addr=%0d data=%h exp addr=%0d data=%h",
                 cyc, slot_mem_addr, slot_wr_data, e.a, e.d);
      end
    end
    vecs++;
    if (mmio_rd_valid === 1'b1) begin
      if (rq.size() == 0) begin
        errs++; $display("FAIL rd_valid cyc=%0d got unexpected valid data=%h exp none", cyc, mmio_rd_data);
      end else begin
        r = rq.pop_front();
        if (mmio_rd_data !== r.d || r.due != cyc) begin
          errs++;
          $display("FAIL rd_data cyc=%0d got=%h exp=%h due=%0d", cyc, mmio_rd_data, r.d, r.due);
        end
        last_data = r.d;
      end
    end else begin
      if (rq.size() > 0 && rq[0].due <= cyc) begin
        r = rq.pop_front();
        errs++; $display("FAIL rd_valid cyc=%0d got valid=%b exp 1 data=%h", cyc, mmio_rd_valid, r.d);
      end else if (mmio_rd_data !== last_data) begin
        errs++; $display("FAIL rd_hold cyc=%0d got=%h exp=%h", cyc, mmio_rd_data, last_data);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++; $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial begin
    int op, rg;
    logic [5:0] sl;
    logic [20:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", slot_cs, 0);
    chk("rst_strobes", slot_mem_rd | slot_mem_wr, 0);
    chk("rst_valid", {63'b0, mmio_rd_valid}, 0);
    chk("rst_data", {32'b0, mmio_rd_data}, 0);
    reset = 0;
    mon_en = 1;

    // Directed cases
    issue(1, 0, 1, 21'h00A3, 32'hA5A5_0001);   // slot 5 reg 3
    idle();
    issue(1, 0, 1, 21'h0020, 32'h11);          // slot 1 reg 0
    issue(1, 0, 1, 21'h0082, 32'h42);          // slot 4 reg 2
    issue(1, 1, 0, 21'h0020, '0);
    issue(1, 1, 0, 21'h0082, '0);
    idle();
    issue(1, 1, 0, 21'h0040, '0);              // absent slot 2
    issue(1, 0, 1, 21'h0041, 32'hDEAD_BEEF);   // absent slot 2 write dropped
    issue(1, 1, 1, 21'h0020, 32'h1234);        // illegal
    issue(1, 0, 0, 21'h0020, '0);              // cs only
    issue(0, 1, 0, 21'h0020, '0);              // read without cs
    issue(1, 1, 0, 21'h1FF7E3, '0);            // upper bits ignored, slot 63
    repeat (3) idle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      sl = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 5));
      rg = $urandom_range(0, 3);
      a = {10'($urandom), sl, 5'(rg)};
      case (op)
        0, 1, 2, 3: issue(1, 1, 0, a, '0);
        4, 5, 6:    issue(1, 0, 1, a, $urandom);
        7:          issue(1, 1, 1, a, $urandom);
        8:          issue(1, 0, 0, a, $urandom);
        default:    issue(0, 1'($urandom), 1'($urandom), a, $urandom);
      endcase
    end

    // Error-log sequence (ordinary slot traffic when the log is absent)
    issue(1, 0, 1, 21'h07E0, '0);
    issue(1, 1, 0, 21'h0040, '0);
    issue(1, 0, 1, 21'h0041, 32'h5);
    issue(1, 1, 0, 21'h0042, '0);
    issue(1, 1, 1, 21'h0060, '0);
    issue(1, 1, 0, 21'h07E0, '0);
    issue(1, 1, 0, 21'h07E1, '0);
    issue(1, 0, 1, 21'h07E0, '0);
    issue(1, 1, 0, 21'h07E0, '0);
    repeat (4) idle();

    @(negedge clk);
    mon_en = 0;
    chk("drain_rq", 64'(rq.size()), 0);
    rq.delete(); sq.delete();

    // Reset during S2 of a read
    @(posedge clk); #1;
    mmio_cs = 1; mmio_read = 1; mmio_write = 0; mmio_addr = 21'h0020;
    @(posedge clk); #1;
    mmio_cs = 0; mmio_read = 0;
    chk("s2_rd_strobe", slot_mem_rd, 64'h2);
    #2 reset = 1;
    #1 chk("s2_rst_rd", slot_mem_rd, 0);
    chk("s2_rst_cs", slot_cs, 0);
    @(negedge clk); reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_valid", {63'b0, mmio_rd_valid}, 0);
    end
    chk("post_rst_data", {32'b0, mmio_rd_data}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
